csa_stream_xor: RTL and testbench

Stream-layer combiner for the CSA descrambler data path. Sits downstream of the keystream generator (the stream-cipher core built from the 5-to-2 sbox bank) and consumes its keystream bytes. It XORs them onto incoming scrambled payload bytes and forwards the result to the block-cipher layer. The first SKIP_BYTES of each packet pass through unmodified. Keystream is buffered in a small FIFO so the generator and the payload source can run decoupled.

---
 rtl/csa_stream_xor_if.sv | 11 +
 rtl/csa_stream_xor.sv | 183 ++++++++++++++++++
 tb/tb_csa_stream_xor.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_stream_xor_if.sv
// Byte stream handshake bundle: vld/dat driven by the producer, rdy by the consumer.
// Latency: none (wires only).
// Backpressure: a transfer happens on a rising edge where vld and rdy are both high.
interface csa_stream_xor_if;
    logic       vld;
    logic       rdy;
    logic [7:0] dat;

    modport master (output vld, output dat, input rdy);
    modport slave  (input vld, input dat, output rdy);
endinterface

// File: rtl/csa_stream_xor.sv
// CSA stream-layer combiner: XORs buffered keystream onto payload after SKIP_BYTES clear bytes; CSA_XOR_BYPASS_EN adds bypass_i.
// Latency: 1 cycle from ct handshake to pt_vld (registered output); done 1 cycle after final pt handshake.
// Backpressure: ct/ks ready are decoded from registered state and pt rdy only; output holds until pt rdy.
module csa_stream_xor #(
    parameter int KS_DEPTH   = 4,
    parameter int SKIP_BYTES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [7:0]        pkt_len_i,
`ifdef CSA_XOR_BYPASS_EN
    input  logic              bypass_i,
`endif
    csa_stream_xor_if.slave   ks_if,
    csa_stream_xor_if.slave   ct_if,
    csa_stream_xor_if.master  pt_if,
    output logic              busy_o,
    output logic              done_o
);

    localparam int AW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(KS_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {IDLE, PASS, XOR, FIN} state_e;

    state_e          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      ks_cnt_q, ks_cnt_d;
    logic [7:0]      pt_dat_q, pt_dat_d;
    logic            pt_vld_q, pt_vld_d;
    logic            done_q, done_d;
    logic            bypass_q, bypass_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     fill_q, fill_d;
    logic [7:0]      ks_mem_q [KS_DEPTH];

    logic            start_byp;
    logic            fifo_full, fifo_empty, out_free;
    logic            ks_push, ct_hs, xor_pop, last_byte;
    logic [7:0]      ks_need;

`ifdef CSA_XOR_BYPASS_EN
    assign start_byp = bypass_i;
`else
    assign start_byp = 1'b0;
`endif

    assign fifo_full  = (fill_q == FULL_CNT);
    assign fifo_empty = (fill_q == '0);
    assign out_free   = !pt_vld_q || pt_if.rdy;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign pt_if.vld  = pt_vld_q;
    assign pt_if.dat  = pt_dat_q;

    // Keystream still owed to this packet; the generator is never drained past it.
    always_comb begin
        ks_need = 8'd0;
        if (!bypass_q && (int'(len_q) > SKIP_BYTES))
            ks_need = 8'(int'(len_q) - SKIP_BYTES);
    end

    assign ks_if.rdy = busy_o && !fifo_full && (ks_cnt_q < ks_need);
    assign ct_if.rdy = ((state_q == PASS) || ((state_q == XOR) && !fifo_empty)) && out_free;

    assign ks_push   = ks_if.vld && ks_if.rdy;
    assign ct_hs     = ct_if.vld && ct_if.rdy;
    assign xor_pop   = ct_hs && (state_q == XOR);
    assign last_byte = (byte_cnt_q == len_q - 8'd1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        ks_cnt_d   = ks_cnt_q;
        pt_dat_d   = pt_dat_q;
        pt_vld_d   = pt_vld_q;
        done_d     = 1'b0;
        bypass_d   = bypass_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;

        if (ks_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            ks_cnt_d = ks_cnt_q + 8'd1;
        end
        if (xor_pop)
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({ks_push, xor_pop})
            2'b10:   fill_d = fill_q + (AW+1)'(1);
            2'b01:   fill_d = fill_q - (AW+1)'(1);
            default: fill_d = fill_q;
        endcase

        if (ct_hs) begin
            pt_vld_d   = 1'b1;
            pt_dat_d   = (state_q == XOR) ? (ct_if.dat ^ ks_mem_q[rd_ptr_q]) : ct_if.dat;
            byte_cnt_d = byte_cnt_q + 8'd1;
        end else if (pt_if.rdy) begin
            pt_vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d      = pkt_len_i;
                    byte_cnt_d = 8'd0;
                    ks_cnt_d   = 8'd0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    fill_d     = '0;
                    bypass_d   = start_byp;
                    if (pkt_len_i == 8'd0)
                        state_d = FIN;
                    else if ((SKIP_BYTES == 0) && !start_byp)
                        state_d = XOR;
                    else
                        state_d = PASS;
                end
            end
            PASS: begin
                if (ct_hs) begin
                    if (last_byte)
                        state_d = FIN;
                    else if (!bypass_q && (int'(byte_cnt_q) == SKIP_BYTES - 1))
                        state_d = XOR;
                end
            end
            XOR: begin
                if (ct_hs && last_byte)
                    state_d = FIN;
            end
            FIN: begin
                // Finish as soon as the last output byte is gone or leaving this edge.
                if (out_free) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= 8'd0;
            byte_cnt_q <= 8'd0;
            ks_cnt_q   <= 8'd0;
            pt_dat_q   <= 8'd0;
            pt_vld_q   <= 1'b0;
            done_q     <= 1'b0;
            bypass_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            ks_cnt_q   <= ks_cnt_d;
            pt_dat_q   <= pt_dat_d;
            pt_vld_q   <= pt_vld_d;
            done_q     <= done_d;
            bypass_q   <= bypass_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
        end
    end

    // Storage needs no reset: the fill count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (ks_push)
            ks_mem_q[wr_ptr_q] <= ks_if.dat;
    end

endmodule

// File: tb/tb_csa_stream_xor.sv
// Randomized bench for csa_stream_xor: per-scenario tasks compare the pt stream against a byte-level model.
module tb_csa_stream_xor;
    localparam int KS_DEPTH = 4;
    localparam int SKIP     = 8;
    localparam int BUDGET   = 3000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic [7:0] pkt_len_i;
`ifdef CSA_XOR_BYPASS_EN
    logic       bypass_i;
`endif
    logic       busy_o, done_o;

    csa_stream_xor_if ks_if ();
    csa_stream_xor_if ct_if ();
    csa_stream_xor_if pt_if ();

    csa_stream_xor #(.KS_DEPTH(KS_DEPTH), .SKIP_BYTES(SKIP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .pkt_len_i (pkt_len_i),
`ifdef CSA_XOR_BYPASS_EN
        .bypass_i  (bypass_i),
`endif
        .ks_if     (ks_if),
        .ct_if     (ct_if),
        .pt_if     (pt_if),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ct_src [256];
    logic [7:0] ks_src [256];
    logic [7:0] got [$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_ks_hs, n_ct_hs, done_cyc, last_pt_cyc, start_cyc, busy_cycles;
    int ks_rdy_seen, ct_rdy_seen, empty_viol, hold_viol;
    bit timed_out, aborted, busy_at_done;

    // Reference: clear bytes first, then byte i meets keystream byte i-SKIP.
    function automatic logic [7:0] model_pt(input int i, input bit byp);
        if (byp || i < SKIP) return ct_src[i];
        return ct_src[i] ^ ks_src[i - SKIP];
    endfunction

    function automatic int model_ks(input int len, input bit byp);
        if (byp) return 0;
        return (len > SKIP) ? len - SKIP : 0;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            ct_src[i] = 8'($urandom);
            ks_src[i] = 8'($urandom);
        end
    endtask

    task automatic run_packet(input int len, input bit byp, input int gap_at, input int gap_len,
                              input bit rnd_rdy, input int start2_at, input int rst_at);
        int ks_idx, ct_idx;
        bit prev_hold, finished, ks_hs, ct_hs, pt_hs;
        logic [7:0] prev_dat;
        ks_idx = 0; ct_idx = 0; prev_hold = 0; prev_dat = 8'd0; finished = 0;
        n_ks_hs = 0; n_ct_hs = 0; done_cyc = -100; last_pt_cyc = -100; start_cyc = 0;
        busy_cycles = 0; ks_rdy_seen = 0; ct_rdy_seen = 0; empty_viol = 0; hold_viol = 0;
        timed_out = 0; aborted = 0; busy_at_done = 0;
        got.delete();
        @(posedge clk); #1;
        start_i = 1'b1; pkt_len_i = 8'(len);
`ifdef CSA_XOR_BYPASS_EN
        bypass_i = byp;
`endif
        ks_if.vld = 1'b1; ks_if.dat = ks_src[0];
        ct_if.vld = (len > 0); ct_if.dat = ct_src[0];
        pt_if.rdy = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (k == 0) start_cyc = cyc;
            if (busy_o) busy_cycles++;
            if (ks_if.rdy) ks_rdy_seen++;
            if (ct_if.rdy) ct_rdy_seen++;
            if (!byp && n_ct_hs >= SKIP && n_ct_hs < len && n_ks_hs == n_ct_hs - SKIP && ct_if.rdy)
                empty_viol++;
            if (prev_hold && (!pt_if.vld || pt_if.dat !== prev_dat)) hold_viol++;
            prev_hold = pt_if.vld && !pt_if.rdy;
            prev_dat  = pt_if.dat;
            ks_hs = ks_if.vld && ks_if.rdy;
            ct_hs = ct_if.vld && ct_if.rdy;
            pt_hs = pt_if.vld && pt_if.rdy;
            if (pt_hs) begin got.push_back(pt_if.dat); last_pt_cyc = cyc; end
            if (ks_hs) n_ks_hs++;
            if (ct_hs) n_ct_hs++;
            if (done_o) begin done_cyc = cyc; busy_at_done = busy_o; finished = 1; break; end
            if (rst_at >= 0 && n_ct_hs >= rst_at) begin
                @(posedge clk); #1;
                rst_n = 1'b0; aborted = 1;
                break;
            end
            @(posedge clk); #1;
            if (ks_hs) ks_idx++;
            if (ct_hs) ct_idx++;
            ks_if.vld = !(k >= gap_at && k < gap_at + gap_len);
            ks_if.dat = ks_src[ks_idx & 255];
            ct_if.vld = (ct_idx < len);
            ct_if.dat = ct_src[ct_idx & 255];
            pt_if.rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            start_i   = (k == start2_at);
            pkt_len_i = (k == start2_at) ? 8'd3 : 8'(len);
        end
        if (!finished && !aborted) timed_out = 1;
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; pkt_len_i = 8'd0;
`ifdef CSA_XOR_BYPASS_EN
        bypass_i = 1'b0;
`endif
        ks_if.vld = 1'b1; ks_if.dat = 8'h5A; ct_if.vld = 1'b1; ct_if.dat = 8'hC3; pt_if.rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (ks_if.rdy !== 1'b0) begin n_fail++; $display("FAIL reset ks_ready: got %b expected 0", ks_if.rdy); end
        n_checks++; if (ct_if.rdy !== 1'b0) begin n_fail++; $display("FAIL reset ct_ready: got %b expected 0", ct_if.rdy); end
        n_checks++; if (pt_if.vld !== 1'b0) begin n_fail++; $display("FAIL reset pt_valid: got %b expected 0", pt_if.vld); end
        n_checks++; if (pt_if.dat !== 8'h00) begin n_fail++; $display("FAIL reset pt_data: got %h expected 00", pt_if.dat); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done_o); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // Idle with keystream offered: nothing may be taken.
        n_checks++; if (ks_if.rdy !== 1'b0) begin n_fail++; $display("FAIL idle ks_ready: got %b expected 0", ks_if.rdy); end
        n_checks++; if (ct_if.rdy !== 1'b0) begin n_fail++; $display("FAIL idle ct_ready: got %b expected 0", ct_if.rdy); end
        ks_if.vld = 1'b0; ct_if.vld = 1'b0;
    endtask

    task automatic test_xor_basic();
        for (int i = 0; i < 256; i++) begin
            ct_src[i] = 8'(i);
            ks_src[i] = 8'(8'hA0 + i);
        end
        run_packet(12, 1'b0, -1, 0, 1'b0, -1, -1);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic timeout: got no done expected done"); end
        n_checks++; if (got.size() != 12) begin n_fail++; $display("FAIL basic count: got %0d expected 12", got.size()); end
        for (int i = 0; i < got.size() && i < 12; i++) begin
            n_checks++;
            if (got[i] !== model_pt(i, 1'b0)) begin n_fail++; $display("FAIL basic byte%0d: got %h expected %h", i, got[i], model_pt(i, 1'b0)); end
        end
        n_checks++; if (n_ks_hs != 4) begin n_fail++; $display("FAIL basic ks_hs: got %0d expected 4", n_ks_hs); end
        n_checks++; if (done_cyc != last_pt_cyc + 1) begin n_fail++; $display("FAIL basic done_time: got %0d expected %0d", done_cyc, last_pt_cyc + 1); end
        n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic busy_at_done: got %b expected 0", busy_at_done); end
        @(negedge clk);
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL basic done_pulse: got %b expected 0", done_o); end
    endtask

    task automatic test_short_packet();
        fill_random();
        run_packet(5, 1'b0, -1, 0, 1'b0, -1, -1);
        n_checks++; if (got.size() != 5) begin n_fail++; $display("FAIL short count: got %0d expected 5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            n_checks++;
            if (got[i] !== ct_src[i]) begin n_fail++; $display("FAIL short byte%0d: got %h expected %h", i, got[i], ct_src[i]); end
        end
        n_checks++; if (ks_rdy_seen != 0) begin n_fail++; $display("FAIL short ks_ready: got %0d cycles expected 0", ks_rdy_seen); end
        n_checks++; if (done_cyc != last_pt_cyc + 1) begin n_fail++; $display("FAIL short done_time: got %0d expected %0d", done_cyc, last_pt_cyc + 1); end
    endtask

    task automatic test_zero_len();
        run_packet(0, 1'b0, -1, 0, 1'b0, -1, -1);
        n_checks++; if (ct_rdy_seen != 0) begin n_fail++; $display("FAIL zero ct_ready: got %0d cycles expected 0", ct_rdy_seen); end
        n_checks++; if (done_cyc != start_cyc + 1) begin n_fail++; $display("FAIL zero done_time: got %0d expected %0d", done_cyc, start_cyc + 1); end
        n_checks++; if (busy_cycles != 1) begin n_fail++; $display("FAIL zero busy_len: got %0d expected 1", busy_cycles); end
        n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL zero count: got %0d expected 0", got.size()); end
    endtask

    task automatic test_stall_backpressure();
        fill_random();
        run_packet(40, 1'b0, 12, 10, 1'b1, -1, -1);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL stall timeout: got no done expected done"); end
        n_checks++; if (got.size() != 40) begin n_fail++; $display("FAIL stall count: got %0d expected 40", got.size()); end
        for (int i = 0; i < got.size() && i < 40; i++) begin
            n_checks++;
            if (got[i] !== model_pt(i, 1'b0)) begin n_fail++; $display("FAIL stall byte%0d: got %h expected %h", i, got[i], model_pt(i, 1'b0)); end
        end
        n_checks++; if (n_ks_hs != 32) begin n_fail++; $display("FAIL stall ks_hs: got %0d expected 32", n_ks_hs); end
        n_checks++; if (empty_viol != 0) begin n_fail++; $display("FAIL stall ct_ready_empty: got %0d cycles expected 0", empty_viol); end
        n_checks++; if (hold_viol != 0) begin n_fail++; $display("FAIL stall pt_hold: got %0d changes expected 0", hold_viol); end
    endtask

    task automatic test_start_ignored_and_reset();
        fill_random();
        run_packet(20, 1'b0, -1, 0, 1'b1, 5, -1);
        n_checks++; if (got.size() != 20) begin n_fail++; $display("FAIL restart count: got %0d expected 20", got.size()); end
        for (int i = 0; i < got.size() && i < 20; i++) begin
            n_checks++;
            if (got[i] !== model_pt(i, 1'b0)) begin n_fail++; $display("FAIL restart byte%0d: got %h expected %h", i, got[i], model_pt(i, 1'b0)); end
        end
        n_checks++; if (n_ks_hs != 12) begin n_fail++; $display("FAIL restart ks_hs: got %0d expected 12", n_ks_hs); end

        fill_random();
        run_packet(40, 1'b0, -1, 0, 1'b1, 6, 20);
        n_checks++; if (!aborted) begin n_fail++; $display("FAIL midrst reached: got %b expected 1", aborted); end
        #1;
        n_checks++; if (pt_if.vld !== 1'b0 || pt_if.dat !== 8'h00) begin n_fail++; $display("FAIL midrst pt: got vld=%b dat=%h expected 0/00", pt_if.vld, pt_if.dat); end
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL midrst status: got busy=%b done=%b expected 0/0", busy_o, done_o); end
        n_checks++; if (ks_if.rdy !== 1'b0 || ct_if.rdy !== 1'b0) begin n_fail++; $display("FAIL midrst ready: got ks=%b ct=%b expected 0/0", ks_if.rdy, ct_if.rdy); end
        ks_if.vld = 1'b0; ct_if.vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        fill_random();
        run_packet(40, 1'b0, -1, 0, 1'b1, -1, -1);
        n_checks++; if (got.size() != 40) begin n_fail++; $display("FAIL fresh count: got %0d expected 40", got.size()); end
        for (int i = 0; i < got.size() && i < 40; i++) begin
            n_checks++;
            if (got[i] !== model_pt(i, 1'b0)) begin n_fail++; $display("FAIL fresh byte%0d: got %h expected %h", i, got[i], model_pt(i, 1'b0)); end
        end
        n_checks++; if (n_ks_hs != 32) begin n_fail++; $display("FAIL fresh ks_hs: got %0d expected 32", n_ks_hs); end
    endtask

    task automatic test_back_to_back();
        int len;
        for (int p = 0; p < 5; p++) begin
            fill_random();
            len = (p == 0) ? SKIP + 1 : $urandom_range(0, 60);
            run_packet(len, 1'b0, $urandom_range(0, 30), $urandom_range(0, 8), 1'b1, -1, -1);
            n_checks++; if (timed_out || got.size() != len) begin n_fail++; $display("FAIL b2b%0d count: got %0d expected %0d", p, got.size(), len); end
            for (int i = 0; i < got.size() && i < len; i++) begin
                n_checks++;
                if (got[i] !== model_pt(i, 1'b0)) begin n_fail++; $display("FAIL b2b%0d byte%0d: got %h expected %h", p, i, got[i], model_pt(i, 1'b0)); end
            end
            n_checks++; if (n_ks_hs != model_ks(len, 1'b0)) begin n_fail++; $display("FAIL b2b%0d ks_hs: got %0d expected %0d", p, n_ks_hs, model_ks(len, 1'b0)); end
            n_checks++; if (empty_viol != 0 || hold_viol != 0) begin n_fail++; $display("FAIL b2b%0d protocol: got empty=%0d hold=%0d expected 0/0", p, empty_viol, hold_viol); end
        end
    endtask

`ifdef CSA_XOR_BYPASS_EN
    task automatic test_bypass();
        fill_random();
        run_packet(16, 1'b1, -1, 0, 1'b1, -1, -1);
        n_checks++; if (got.size() != 16) begin n_fail++; $display("FAIL bypass count: got %0d expected 16", got.size()); end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_checks++;
            if (got[i] !== model_pt(i, 1'b1)) begin n_fail++; $display("FAIL bypass byte%0d: got %h expected %h", i, got[i], model_pt(i, 1'b1)); end
        end
        n_checks++; if (n_ks_hs != 0 || ks_rdy_seen != 0) begin n_fail++; $display("FAIL bypass ks: got hs=%0d rdy=%0d expected 0/0", n_ks_hs, ks_rdy_seen); end
        bypass_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_xor_basic();
        test_short_packet();
        test_zero_len();
        test_stall_backpressure();
        test_start_ignored_and_reset();
        test_back_to_back();
`ifdef CSA_XOR_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
